// File: rtl/ov5640_capture_top_if.sv
// DVP byte bundle in, packed pixel bundle out.
// master drives bytes/sync and takes pixels; slave is the capture core.
interface ov5640_capture_top_if;
  logic [7:0]  data_in;
  logic        vsync;
  logic        href;
  logic [15:0] pre_data;
  logic        pre_de;
  logic        vs_o;

  modport master (
    output data_in, vsync, href,
    input  pre_data, pre_de, vs_o
  );

  modport slave (
    input  data_in, vsync, href,
    output pre_data, pre_de, vs_o
  );
endinterface

// File: rtl/ov5640_capture_top.sv
// OV5640 front end: power-up sequencing, SCCB register init, DVP to 16-bit pixels.
// Ports: pclk_2x/rst_n, dvp bundle, scl/sda, cam_rest/pwdn/xclk, init_over, pre_clk.
module ov5640_capture_top #(
  parameter int         PWR_WAIT = 1000,
  parameter int         SCL_DIV  = 125,
  parameter logic [7:0] DEV_ID   = 8'h78,
  parameter int         INIT_NUM = 8
) (
  input  logic                pclk_2x,
  input  logic                rst_n,
  ov5640_capture_top_if.slave dvp,
  output logic                scl,
  inout  wire                 sda,
  output logic                cam_rest,
  output logic                pwdn,
  output logic                xclk,
  output logic                init_over,
  output logic                pre_clk
);

  localparam int CW = $clog2(PWR_WAIT + 1);
  localparam int DW = $clog2(SCL_DIV + 1);
  localparam int IW = $clog2(INIT_NUM + 1);

  typedef enum logic [2:0] {
    PWR_ON, PD_REL, RST_REL, CFG, DONE
  } st_e;

  st_e         st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [5:0]  slot_q, slot_d;
  logic [IW-1:0] idx_q, idx_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic        xclk_q;
  logic [23:0] rom;
  logic [35:0] frame;

  wire wait_end = (cnt_q == CW'(PWR_WAIT - 1));
  wire qtr_end  = (div_q == DW'(SCL_DIV - 1));
  wire slot_end = qtr_end & (qtr_q == 2'd3);
  // slot 0 START, 1..36 bits, 37 STOP, 38 idle gap
  wire xfer_end = slot_end & (slot_q == 6'd38);
  wire last_idx = (idx_q == IW'(INIT_NUM - 1));

  always_comb begin
    rom = 24'h0;
    case (32'(idx_q))
      0: rom = 24'h3008_82;
      1: rom = 24'h3103_02;
      2: rom = 24'h3017_ff;
      3: rom = 24'h3018_ff;
      4: rom = 24'h4300_61;
      5: rom = 24'h501f_01;
      6: rom = 24'h3820_40;
      7: rom = 24'h3821_06;
      default: rom = 24'h0;
    endcase
  end

  // X bits are 1 so the master releases sda for them
  assign frame = {DEV_ID, 1'b1, rom[23:16], 1'b1,
                  rom[15:8], 1'b1, rom[7:0], 1'b1};

  always_ff @(posedge pclk_2x) begin
    if (!rst_n) st_q <= PWR_ON;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      PWR_ON:  if (wait_end) st_d = PD_REL;
      PD_REL:  if (wait_end) st_d = RST_REL;
      RST_REL: if (wait_end) st_d = CFG;
      CFG:     if (xfer_end && last_idx) st_d = DONE;
      DONE:    st_d = DONE;
      default: st_d = PWR_ON;
    endcase
  end

  always_comb begin
    pwdn      = (st_q == PWR_ON);
    cam_rest  = (st_q == RST_REL) | (st_q == CFG) | (st_q == DONE);
    init_over = (st_q == DONE);
    scl_d     = 1'b1;
    sda_d     = 1'b1;
    if (st_q == CFG) begin
      unique case (1'b1)
        slot_q == 6'd0: begin
          scl_d = (qtr_q != 2'd3);
          sda_d = (qtr_q == 2'd0);
        end
        slot_q == 6'd37: begin
          scl_d = (qtr_q != 2'd0);
          sda_d = qtr_q[1];
        end
        slot_q == 6'd38: begin
          scl_d = 1'b1;
          sda_d = 1'b1;
        end
        default: begin
          scl_d = qtr_q[0] ^ qtr_q[1];
          sda_d = frame[6'd36 - slot_q];
        end
      endcase
    end
  end

  always_comb begin
    cnt_d  = '0;
    div_d  = '0;
    qtr_d  = '0;
    slot_d = '0;
    idx_d  = idx_q;
    unique case (1'b1)
      st_q == CFG: begin
        div_d  = qtr_end ? '0 : div_q + 1'b1;
        qtr_d  = qtr_end ? qtr_q + 2'd1 : qtr_q;
        slot_d = !slot_end ? slot_q :
                 (slot_q == 6'd38) ? 6'd0 : slot_q + 6'd1;
        idx_d  = xfer_end ? idx_q + 1'b1 : idx_q;
      end
      st_q == DONE: begin
        idx_d = idx_q;
      end
      default: cnt_d = wait_end ? '0 : cnt_q + 1'b1;
    endcase
  end

  always_ff @(posedge pclk_2x) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= '0;
      qtr_q  <= '0;
      slot_q <= '0;
      idx_q  <= '0;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
      xclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      qtr_q  <= qtr_d;
      slot_q <= slot_d;
      idx_q  <= idx_d;
      scl_q  <= scl_d;
      sda_q  <= sda_d;
      xclk_q <= ~xclk_q;
    end
  end

  assign scl     = scl_q;
  assign sda     = sda_q ? 1'bz : 1'b0;
  assign xclk    = xclk_q;
  assign pre_clk = pclk_2x;

  logic [7:0]  d_q, hi_q;
  logic        href_q, vs_q, en_q, ph_q, de_q, vso_q;
  logic [15:0] pix_q;

  // capture arms only on a frame start seen after init
  wire rise = dvp.vsync & ~vs_q;
  wire en_d = en_q | (init_over & rise);
  wire act  = en_q & vs_q & href_q;

  always_ff @(posedge pclk_2x) begin
    if (!rst_n) begin
      d_q    <= '0;
      hi_q   <= '0;
      href_q <= 1'b0;
      vs_q   <= 1'b0;
      en_q   <= 1'b0;
      ph_q   <= 1'b0;
      de_q   <= 1'b0;
      vso_q  <= 1'b0;
      pix_q  <= '0;
    end else begin
      d_q    <= dvp.data_in;
      href_q <= dvp.href;
      vs_q   <= dvp.vsync;
      en_q   <= en_d;
      vso_q  <= en_d & dvp.vsync;
      ph_q   <= act & ~ph_q;
      de_q   <= act & ph_q;
      if (act & ~ph_q) hi_q  <= d_q;
      if (act & ph_q)  pix_q <= {hi_q, d_q};
    end
  end

  assign dvp.pre_data = pix_q;
  assign dvp.pre_de   = de_q;
  assign dvp.vs_o     = vso_q;

endmodule

// File: tb/tb_ov5640_capture_top.sv
// Bench for ov5640_capture_top: power timing, SCCB decode, reset replay,
// frame gating and pixel packing against a byte-list reference model.
module tb_ov5640_capture_top;

  localparam int PW = 20;
  localparam int SD = 4;
  localparam int NI = 8;

  logic clk;
  logic rst_n;
  wire  sda;
  logic scl, cam_rest, pwdn, xclk, init_over, pre_clk;

  pullup (sda);

  ov5640_capture_top_if dvp ();

  ov5640_capture_top #(
    .PWR_WAIT (PW),
    .SCL_DIV  (SD),
    .DEV_ID   (8'h78),
    .INIT_NUM (NI)
  ) dut (
    .pclk_2x   (clk),
    .rst_n     (rst_n),
    .dvp       (dvp.slave),
    .scl       (scl),
    .sda       (sda),
    .cam_rest  (cam_rest),
    .pwdn      (pwdn),
    .xclk      (xclk),
    .init_over (init_over),
    .pre_clk   (pre_clk)
  );

  logic [23:0] rom_m [NI] = '{24'h300882, 24'h310302, 24'h3017ff,
                              24'h3018ff, 24'h430061, 24'h501f01,
                              24'h382040, 24'h382106};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  wire sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SCCB bus monitor
  logic [36:0] trans[$];
  int          tbits[$];
  int          starts = 0;
  int          first_start = -1;
  int          last_stop = -1;
  int          idle_bad = 0;
  int          per_bad = 0;

  initial begin
    logic        scl_p, sda_p, busy;
    logic [36:0] sh;
    int          nb, last_rise;
    scl_p = 1'b1; sda_p = 1'b1; busy = 1'b0;
    sh = '0; nb = 0; last_rise = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0; scl_p = 1'b1; sda_p = 1'b1;
        last_rise = -1; last_stop = -1;
      end else begin
        if (scl && scl_p && sda_p && !sda_v) begin
          if (last_stop >= 0 && cyc - last_stop < 4 * SD) idle_bad++;
          busy = 1'b1; nb = 0; sh = '0; last_rise = -1;
          starts++;
          if (first_start < 0) first_start = cyc;
        end else if (scl && scl_p && !sda_p && sda_v) begin
          if (busy) begin
            trans.push_back(sh);
            tbits.push_back(nb);
            last_stop = cyc;
          end
          busy = 1'b0;
        end
        if (scl && !scl_p && busy) begin
          sh = {sh[35:0], sda_v};
          nb++;
          if (last_rise >= 0 && cyc - last_rise != 4 * SD) per_bad++;
          last_rise = cyc;
        end
        scl_p = scl;
        sda_p = sda_v;
      end
    end
  end

  // pixel monitor
  logic [15:0] gotq[$];
  int          gotc[$];
  int          de_bad = 0;
  int          hold_bad = 0;

  initial begin
    logic        de_p;
    logic [15:0] pd_p;
    de_p = 1'b0; pd_p = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dvp.pre_de) begin
          gotq.push_back(dvp.pre_data);
          gotc.push_back(cyc);
          if (de_p) de_bad++;
        end else if (dvp.pre_data !== pd_p) begin
          hold_bad++;
        end
      end
      de_p = dvp.pre_de;
      pd_p = dvp.pre_data;
    end
  end

  logic [15:0] expq[$];
  logic [7:0]  pat = 8'h00;
  int          first_c0 = -1;

  task automatic send_line(input int len, input int cut,
                           input bit inc, input bit mdl);
    logic [7:0] b[$];
    logic [7:0] v;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      v = inc ? pat : 8'($urandom);
      if (inc) pat = pat + 8'd1;
      if (i == cut) dvp.vsync = 1'b0;
      if (mdl && first_c0 < 0) first_c0 = cyc;
      dvp.href = 1'b1;
      dvp.data_in = v;
      if (cut < 0 || i < cut) b.push_back(v);
    end
    @(negedge clk);
    dvp.href = 1'b0;
    dvp.data_in = 8'h00;
    if (mdl)
      for (int i = 0; i + 1 < b.size(); i += 2)
        expq.push_back({b[i], b[i+1]});
    repeat (3 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    dvp.vsync = 1'b1;
    chk("vs_o_pre", 32'(dvp.vs_o), 32'd0);
    @(negedge clk);
    chk("vs_o_rise", 32'(dvp.vs_o), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    dvp.vsync = 1'b0;
    chk("vs_o_hold", 32'(dvp.vs_o), 32'd1);
    @(negedge clk);
    chk("vs_o_fall", 32'(dvp.vs_o), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic cmp_pix(input string tag);
    int n;
    chk({tag, "_cnt"}, gotq.size(), expq.size());
    n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int i = 0; i < n; i++)
      chk(tag, 32'(gotq[i]), 32'(expq[i]));
    gotq.delete();
    gotc.delete();
    expq.delete();
  endtask

  initial begin
    int n, r, t;
    rst_n = 1'b0;
    dvp.data_in = 8'h00;
    dvp.vsync = 1'b0;
    dvp.href = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_pwdn", 32'(pwdn), 32'd1);
    chk("rst_cam_rest", 32'(cam_rest), 32'd0);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda_v), 32'd1);
    chk("rst_init_over", 32'(init_over), 32'd0);
    chk("rst_pre_de", 32'(dvp.pre_de), 32'd0);
    chk("rst_pre_data", 32'(dvp.pre_data), 32'd0);
    chk("rst_vs_o", 32'(dvp.vs_o), 32'd0);
    chk("rst_xclk", 32'(xclk), 32'd0);

    rst_n = 1'b1;
    r = cyc;
    n = 0;
    while (pwdn !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    chk("pwdn_time", cyc - r, PW);
    n = 0;
    while (cam_rest !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk("cam_rest_time", cyc - r, 2 * PW);
    n = 0;
    while (first_start < 0 && n < 5000) begin @(negedge clk); n++; end
    t = first_start - r;
    chk("start_window", 32'(t >= 3 * PW && t <= 3 * PW + 4 * SD), 32'd1);
    chk("xclk_div", 32'(xclk ^ dut.xclk_q), 32'd0);

    n = 0;
    while (trans.size() < 2 && n < 5000) begin @(negedge clk); n++; end
    chk("pre_rst_trans", trans.size(), 2);
    chk("e0_dev", 32'(trans[0][36:29]), 32'h78);
    chk("e0_ahi", 32'(trans[0][27:20]), 32'h30);
    chk("e0_alo", 32'(trans[0][18:11]), 32'h08);
    chk("e0_dat", 32'(trans[0][9:2]), 32'h82);

    n = 0;
    while (starts < 3 && n < 5000) begin @(negedge clk); n++; end
    chk("third_start", 32'(starts >= 3), 32'd1);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_scl", 32'(scl), 32'd1);
    chk("mid_rst_sda", 32'(sda_v), 32'd1);
    chk("mid_rst_init_over", 32'(init_over), 32'd0);
    chk("mid_rst_pwdn", 32'(pwdn), 32'd1);
    repeat (2) @(negedge clk);
    trans.delete();
    tbits.delete();
    starts = 0;
    first_start = -1;
    dvp.vsync = 1'b1;
    rst_n = 1'b1;

    n = 0;
    while (init_over !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    chk("init_over", 32'(init_over), 32'd1);
    chk("n_trans", trans.size(), NI);
    for (int e = 0; e < NI && e < trans.size(); e++) begin
      chk("sccb_dev", 32'(trans[e][36:29]), 32'h78);
      chk("sccb_ahi", 32'(trans[e][27:20]), 32'(rom_m[e][23:16]));
      chk("sccb_alo", 32'(trans[e][18:11]), 32'(rom_m[e][15:8]));
      chk("sccb_dat", 32'(trans[e][9:2]), 32'(rom_m[e][7:0]));
      chk("sccb_x", 32'({trans[e][28], trans[e][19],
                         trans[e][10], trans[e][1]}), 32'hf);
      chk("sccb_bits", tbits[e], 37);
    end
    chk("stop_before_init", 32'(last_stop >= 0 && last_stop < cyc), 32'd1);
    chk("sccb_idle", idle_bad, 0);
    chk("sccb_period", per_bad, 0);

    // partial frame already running when init completes
    send_line(12, -1, 1'b0, 1'b0);
    chk("gate_de", gotq.size(), 0);
    chk("gate_vs_o", 32'(dvp.vs_o), 32'd0);
    gotq.delete();
    gotc.delete();
    @(negedge clk);
    dvp.vsync = 1'b0;
    repeat (4) @(negedge clk);

    // incrementing bytes
    pat = 8'h00;
    frame_start();
    for (int l = 0; l < 3; l++) send_line(16, -1, 1'b1, 1'b1);
    frame_end();
    chk("first_px", gotq.size() > 0 ? 32'(gotq[0]) : 32'hdead, 32'h0001);
    chk("first_lat", gotc.size() > 0 ? gotc[0] - first_c0 : -1, 3);
    cmp_pix("incr_px");

    // random bytes, odd and even line lengths
    frame_start();
    send_line(21, -1, 1'b0, 1'b1);
    send_line(18, -1, 1'b0, 1'b1);
    send_line(1, -1, 1'b0, 1'b1);
    for (int l = 0; l < 3; l++)
      send_line($urandom_range(8, 33), -1, 1'b0, 1'b1);
    frame_end();
    cmp_pix("rand_px");

    // vsync drops mid-line
    frame_start();
    send_line(20, 14, 1'b0, 1'b1);
    chk("cut_vs_o", 32'(dvp.vs_o), 32'd0);
    repeat (4) @(negedge clk);
    cmp_pix("cut_px");

    frame_start();
    for (int l = 0; l < 2; l++)
      send_line($urandom_range(6, 20), -1, 1'b0, 1'b1);
    frame_end();
    cmp_pix("next_px");

    chk("init_sticky", 32'(init_over), 32'd1);
    chk("de_width", de_bad, 0);
    chk("data_hold", hold_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
